// File: rtl/traffic_sensor_if.sv
// rtl/traffic_sensor_if.sv - vehicle detector debounce and request interface for a two-street light controller
//
// Purpose:
//   Each raw detector input goes through a 2-flop synchronizer and then a debounce FSM.
//   The FSM states are IDLE, DEB_ON, PRESENT and DEB_OFF, and they use an 8-bit counter.
//   A request latch remembers that a vehicle was seen while the street was red, and holds
//   that request until the street turns green.
//   The optional lamp checker is enabled by defining the macro TL_FAULT_CHECK_EN. It flags
//   illegal lamp combinations, and while the flag is set it forces both requests high.
//
// Parameters:
//   DEB_CYCLES  consecutive synced samples needed to change presence (1..255)
//
// Ports:
//   clk               single clock, rising edge
//   reset             synchronous active-high reset
//   det_a, det_b      raw detectors, asynchronous to clk
//   Ga,Ya,Ra,Gb,Yb,Rb lamp state from the light controller
//   sa, sb            registered vehicle-request outputs
//   pres_a, pres_b    debounced presence
//   fault             sticky illegal-lamp flag (constant 0 without TL_FAULT_CHECK_EN)
module traffic_sensor_if #(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic det_a,
  input  logic det_b,
  input  logic Ga,
  input  logic Ya,
  input  logic Ra,
  input  logic Gb,
  input  logic Yb,
  input  logic Rb,
  output logic sa,
  output logic sb,
  output logic pres_a,
  output logic pres_b,
  output logic fault
);

  typedef enum logic [1:0] {ST_IDLE, ST_DEB_ON, ST_PRESENT, ST_DEB_OFF} deb_state_t;

  localparam logic [7:0] DEB_C = 8'(DEB_CYCLES);

  logic [1:0] w_det;
  logic [1:0] w_green;
  logic [1:0] w_red;
  logic [1:0] r_sync1;
  logic [1:0] r_sync2;
  logic [1:0] w_pres;
  logic [1:0] w_req;
  logic       w_force;
  logic       r_sa;
  logic       r_sb;

  // Bit 0 is street A and bit 1 is street B.
  assign w_det   = {det_b, det_a};
  assign w_green = {Gb, Ga};
  assign w_red   = {Rb, Ra};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 2'b00;
      r_sync2 <= 2'b00;
    end else begin
      r_sync1 <= w_det;
      r_sync2 <= r_sync1;
    end
  end

  for (genvar i = 0; i < 2; i++) begin : g_street
    deb_state_t r_state;
    deb_state_t w_state_nxt;
    logic [7:0] r_cnt;
    logic [7:0] w_cnt_nxt;
    logic       w_pres_i;
    logic       r_req_i;

    always_ff @(posedge clk) begin
      if (reset) begin
        r_state <= ST_IDLE;
        r_cnt   <= 8'd0;
      end else begin
        r_state <= w_state_nxt;
        r_cnt   <= w_cnt_nxt;
      end
    end

    // The counter holds the number of consecutive agreeing samples already seen.
    // A state change is taken on the sample that would bring the count to DEB_CYCLES.
    always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
        ST_IDLE: begin
          if (r_sync2[i]) begin
            if (DEB_C == 8'd1) begin
              w_state_nxt = ST_PRESENT;
              w_cnt_nxt   = 8'd0;
            end else begin
              w_state_nxt = ST_DEB_ON;
              w_cnt_nxt   = 8'd1;
            end
          end
        end
        ST_DEB_ON: begin
          if (!r_sync2[i]) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = 8'd0;
          end else if (r_cnt + 8'd1 >= DEB_C) begin
            w_state_nxt = ST_PRESENT;
            w_cnt_nxt   = 8'd0;
          end else begin
            w_cnt_nxt = r_cnt + 8'd1;
          end
        end
        ST_PRESENT: begin
          if (!r_sync2[i]) begin
            if (DEB_C == 8'd1) begin
              w_state_nxt = ST_IDLE;
              w_cnt_nxt   = 8'd0;
            end else begin
              w_state_nxt = ST_DEB_OFF;
              w_cnt_nxt   = 8'd1;
            end
          end
        end
        ST_DEB_OFF: begin
          if (r_sync2[i]) begin
            w_state_nxt = ST_PRESENT;
            w_cnt_nxt   = 8'd0;
          end else if (r_cnt + 8'd1 >= DEB_C) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = 8'd0;
          end else begin
            w_cnt_nxt = r_cnt + 8'd1;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = 8'd0;
        end
      endcase
    end

    // Presence stays high through DEB_OFF, so a short gap does not drop it.
    always_comb begin
      w_pres_i = (r_state == ST_PRESENT) || (r_state == ST_DEB_OFF);
    end

    // A green lamp takes priority, so the clear wins when set and clear occur together.
    always_ff @(posedge clk) begin
      if (reset) begin
        r_req_i <= 1'b0;
      end else if (w_green[i]) begin
        r_req_i <= 1'b0;
      end else if (w_pres_i && w_red[i]) begin
        r_req_i <= 1'b1;
      end
    end

    assign w_pres[i] = w_pres_i;
    assign w_req[i]  = r_req_i;
  end

`ifdef TL_FAULT_CHECK_EN
  logic w_bad_a;
  logic w_bad_b;
  logic w_illegal;
  logic r_fault;

  // Exactly one lamp per street is lit, and at least one street shows red.
  assign w_bad_a   = !((Ga ^ Ya ^ Ra) && !(Ga && Ya && Ra));
  assign w_bad_b   = !((Gb ^ Yb ^ Rb) && !(Gb && Yb && Rb));
  assign w_illegal = w_bad_a || w_bad_b || !(Ra || Rb);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fault <= 1'b0;
    end else if (w_illegal) begin
      r_fault <= 1'b1;
    end
  end

  // Feeding the illegal-state term in directly makes sa/sb rise on the same edge as fault.
  assign w_force = r_fault || w_illegal;
  assign fault   = r_fault;
`else
  logic w_unused_lamps;

  assign w_unused_lamps = Ya ^ Yb;
  assign w_force        = 1'b0;
  assign fault          = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sa <= 1'b0;
      r_sb <= 1'b0;
    end else begin
      r_sa <= w_pres[0] || w_req[0] || w_force;
      r_sb <= w_pres[1] || w_req[1] || w_force;
    end
  end

  assign sa     = r_sa;
  assign sb     = r_sb;
  assign pres_a = w_pres[0];
  assign pres_b = w_pres[1];

endmodule
